// File: rtl/avalon_mem_burst_splitter_if.sv
// Avalon-MM bus bundle used on both sides of the burst splitter.
//   master modport: the side issuing commands (drives address/read/write/burst/data,
//                   receives waitrequest and read responses).
//   slave modport : the side accepting commands.
// Signals: waitrequest, readdata, readdatavalid, burstcount, writedata,
//          address, write, read, byteenable.
interface avalon_mem_burst_splitter_if #(
  parameter int ADDR_WIDTH      = 27,
  parameter int DATA_WIDTH      = 512,
  parameter int BURST_CNT_WIDTH = 7
);
  localparam int DATA_N_BYTES = (DATA_WIDTH + 7) / 8;

  logic                       waitrequest;
  logic [DATA_WIDTH-1:0]      readdata;
  logic                       readdatavalid;
  logic [BURST_CNT_WIDTH-1:0] burstcount;
  logic [DATA_WIDTH-1:0]      writedata;
  logic [ADDR_WIDTH-1:0]      address;
  logic                       write;
  logic                       read;
  logic [DATA_N_BYTES-1:0]    byteenable;

  modport master (
    input  waitrequest, readdata, readdatavalid,
    output burstcount, writedata, address, write, read, byteenable
  );

  modport slave (
    output waitrequest, readdata, readdatavalid,
    input  burstcount, writedata, address, write, read, byteenable
  );
endinterface

// File: rtl/avalon_mem_burst_splitter.sv
// Avalon-MM burst splitter between AFU user logic and one local-memory bank.
// AFU bursts of up to 2^(AFU_BURST_CNT_WIDTH-1) lines are reissued toward the
// FIU as consecutive bursts of at most 2^(FIU_BURST_CNT_WIDTH-1) lines.
// Command path is combinational; read responses pass straight through.
// Ports:
//   clk   - clock
//   reset - asynchronous, active-high
//   afu   - slave side facing AFU user logic
//   fiu   - master side facing the FIU memory port
module avalon_mem_burst_splitter #(
  parameter int ADDR_WIDTH          = 27,
  parameter int DATA_WIDTH          = 512,
  parameter int AFU_BURST_CNT_WIDTH = 7,
  parameter int FIU_BURST_CNT_WIDTH = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  avalon_mem_burst_splitter_if.slave   afu,
  avalon_mem_burst_splitter_if.master  fiu
);
  localparam int DATA_N_BYTES = (DATA_WIDTH + 7) / 8;
  localparam int unsigned FIU_MAX = 1 << (FIU_BURST_CNT_WIDTH - 1);
  localparam logic [AFU_BURST_CNT_WIDTH-1:0] FIU_MAX_A = AFU_BURST_CNT_WIDTH'(FIU_MAX);
  localparam logic [AFU_BURST_CNT_WIDTH-1:0] ONE_A     = AFU_BURST_CNT_WIDTH'(1);
  localparam logic [FIU_BURST_CNT_WIDTH-1:0] FIU_MAX_F = FIU_BURST_CNT_WIDTH'(FIU_MAX);
  localparam logic [FIU_BURST_CNT_WIDTH-1:0] ONE_F     = FIU_BURST_CNT_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0]          ADDR_STEP = ADDR_WIDTH'(FIU_MAX);

  typedef enum logic [1:0] {IDLE, RD_SPLIT, WR_BURST} state_t;

  state_t                         state_q, state_d;
  logic [ADDR_WIDTH-1:0]          next_addr_q, next_addr_d;
  logic [AFU_BURST_CNT_WIDTH-1:0] total_left_q, total_left_d;
  logic [FIU_BURST_CNT_WIDTH-1:0] chunk_left_q, chunk_left_d;
  // Address/length of the FIU burst currently being filled by write beats;
  // non-opening beats of a chunk repeat these values.
  logic [ADDR_WIDTH-1:0]          cur_addr_q, cur_addr_d;
  logic [FIU_BURST_CNT_WIDTH-1:0] cur_bc_q, cur_bc_d;

  logic [FIU_BURST_CNT_WIDTH-1:0] afu_bc_clamp, left_clamp;
  logic                           rd_last;

  function automatic logic [FIU_BURST_CNT_WIDTH-1:0] clamp(
    input logic [AFU_BURST_CNT_WIDTH-1:0] n
  );
    if (n > FIU_MAX_A) return FIU_MAX_F;
    return n[FIU_BURST_CNT_WIDTH-1:0];
  endfunction

  assign afu_bc_clamp = clamp(afu.burstcount);
  assign left_clamp   = clamp(total_left_q);
  assign rd_last      = (total_left_q <= FIU_MAX_A);

  assign afu.readdata      = DATA_WIDTH'(fiu.readdata);
  assign afu.readdatavalid = fiu.readdatavalid;
  assign fiu.writedata     = DATA_WIDTH'(afu.writedata);
  assign fiu.byteenable    = DATA_N_BYTES'(afu.byteenable);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      next_addr_q  <= '0;
      total_left_q <= '0;
      chunk_left_q <= '0;
      cur_addr_q   <= '0;
      cur_bc_q     <= '0;
    end else begin
      state_q      <= state_d;
      next_addr_q  <= next_addr_d;
      total_left_q <= total_left_d;
      chunk_left_q <= chunk_left_d;
      cur_addr_q   <= cur_addr_d;
      cur_bc_q     <= cur_bc_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    next_addr_d     = next_addr_q;
    total_left_d    = total_left_q;
    chunk_left_d    = chunk_left_q;
    cur_addr_d      = cur_addr_q;
    cur_bc_d        = cur_bc_q;
    fiu.read        = 1'b0;
    fiu.write       = 1'b0;
    fiu.address     = afu.address;
    fiu.burstcount  = afu_bc_clamp;
    afu.waitrequest = fiu.waitrequest;

    unique case (state_q)
      IDLE: begin
        if (afu.read) begin
          fiu.read = 1'b1;
          if (afu.burstcount > FIU_MAX_A) begin
            // AFU is held until the final chunk is accepted.
            afu.waitrequest = 1'b1;
            if (!fiu.waitrequest) begin
              next_addr_d  = afu.address + ADDR_STEP;
              total_left_d = afu.burstcount - FIU_MAX_A;
              state_d      = RD_SPLIT;
            end
          end
        end else if (afu.write) begin
          fiu.write = 1'b1;
          if (!fiu.waitrequest && afu.burstcount > ONE_A) begin
            total_left_d = afu.burstcount - ONE_A;
            chunk_left_d = afu_bc_clamp - ONE_F;
            next_addr_d  = afu.address + ADDR_STEP;
            cur_addr_d   = afu.address;
            cur_bc_d     = afu_bc_clamp;
            state_d      = WR_BURST;
          end
        end
      end

      RD_SPLIT: begin
        fiu.read        = 1'b1;
        fiu.address     = next_addr_q;
        fiu.burstcount  = left_clamp;
        afu.waitrequest = rd_last ? fiu.waitrequest : 1'b1;
        if (!fiu.waitrequest) begin
          next_addr_d  = next_addr_q + ADDR_STEP;
          total_left_d = total_left_q - AFU_BURST_CNT_WIDTH'(left_clamp);
          if (rd_last) state_d = IDLE;
        end
      end

      WR_BURST: begin
        // A beat with chunk_left==0 opens the next FIU burst.
        if (chunk_left_q == '0) begin
          fiu.address    = next_addr_q;
          fiu.burstcount = left_clamp;
        end else begin
          fiu.address    = cur_addr_q;
          fiu.burstcount = cur_bc_q;
        end
        if (afu.write) begin
          fiu.write = 1'b1;
          if (!fiu.waitrequest) begin
            total_left_d = total_left_q - ONE_A;
            if (chunk_left_q == '0) begin
              chunk_left_d = left_clamp - ONE_F;
              next_addr_d  = next_addr_q + ADDR_STEP;
              cur_addr_d   = next_addr_q;
              cur_bc_d     = left_clamp;
            end else begin
              chunk_left_d = chunk_left_q - ONE_F;
            end
            if (total_left_q == ONE_A) state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    if (reset) begin
      fiu.read        = 1'b0;
      fiu.write       = 1'b0;
      afu.waitrequest = 1'b1;
    end
  end

  a_bc_nonzero: assert property (@(posedge clk) disable iff (reset)
    (state_q == IDLE && (afu.read || afu.write)) |-> (afu.burstcount != '0));
  a_rd_wr_excl: assert property (@(posedge clk) disable iff (reset)
    !(afu.read && afu.write));
  a_no_rd_in_wr: assert property (@(posedge clk) disable iff (reset)
    (state_q == WR_BURST) |-> !afu.read);
endmodule

// File: tb/tb_avalon_mem_burst_splitter.sv
module tb_avalon_mem_burst_splitter;
  localparam int AW = 27;
  localparam int DW = 64;

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [2:0]    bc;
    logic [DW-1:0] data;
    logic [7:0]    be;
  } cmd_t;

  logic clk = 1'b0;
  logic reset;
  int unsigned passed = 0;
  int unsigned total  = 0;

  cmd_t          exp_cmd[$];
  logic [DW-1:0] fiu_rd_q[$];
  logic [DW-1:0] exp_rd_q[$];

  always #5 clk = ~clk;

  avalon_mem_burst_splitter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_CNT_WIDTH(7)) afu_bus ();
  avalon_mem_burst_splitter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_CNT_WIDTH(3)) fiu_bus ();

  avalon_mem_burst_splitter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .AFU_BURST_CNT_WIDTH(7), .FIU_BURST_CNT_WIDTH(3)
  ) dut (
    .clk(clk), .reset(reset), .afu(afu_bus), .fiu(fiu_bus)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [2:0] min4(input int unsigned n);
    return (n > 4) ? 3'd4 : 3'(n);
  endfunction

  // FIU-side monitor: compares every accepted command against the scoreboard,
  // and checks read data returned to the AFU.
  initial begin
    cmd_t c;
    logic [DW-1:0] d;
    forever begin
      @(negedge clk);
      if (!reset && (fiu_bus.read || fiu_bus.write) && !fiu_bus.waitrequest) begin
        chk("cmd_expected", exp_cmd.size() != 0, 1);
        if (exp_cmd.size() != 0) begin
          c = exp_cmd.pop_front();
          chk("cmd_is_write", fiu_bus.write, c.wr);
          chk("cmd_addr", fiu_bus.address, c.addr);
          chk("cmd_burstcount", fiu_bus.burstcount, c.bc);
          if (c.wr) begin
            chk("wr_data", fiu_bus.writedata, c.data);
            chk("wr_be", fiu_bus.byteenable, c.be);
          end else begin
            for (int unsigned k = 0; k < c.bc; k++) begin
              d = {$urandom, $urandom};
              fiu_rd_q.push_back(d);
              exp_rd_q.push_back(d);
            end
          end
        end
      end
      if (afu_bus.readdatavalid) begin
        chk("rd_beat_expected", exp_rd_q.size() != 0, 1);
        if (exp_rd_q.size() != 0) chk("rd_data", afu_bus.readdata, exp_rd_q.pop_front());
      end
    end
  end

  // FIU read-response model: returns queued beats in order with random gaps.
  initial begin
    fiu_bus.readdatavalid = 1'b0;
    fiu_bus.readdata      = '0;
    forever begin
      @(posedge clk); #1;
      if (fiu_rd_q.size() != 0 && $urandom_range(0, 3) != 0) begin
        fiu_bus.readdatavalid = 1'b1;
        fiu_bus.readdata      = fiu_rd_q.pop_front();
      end else begin
        fiu_bus.readdatavalid = 1'b0;
      end
    end
  end

  task automatic push_cmd(input bit wr, input logic [AW-1:0] addr, input logic [2:0] bc,
                          input logic [DW-1:0] data, input logic [7:0] be);
    cmd_t c;
    c.wr = wr; c.addr = addr; c.bc = bc; c.data = data; c.be = be;
    exp_cmd.push_back(c);
  endtask

  task automatic do_read(input logic [AW-1:0] base, input int unsigned b, input bit stalls);
    int unsigned nch = (b + 3) / 4;
    int unsigned k = 0, n = 0;
    bit done = 0, stall;
    logic [AW-1:0] a;
    for (int unsigned i = 0; i < nch; i++) begin
      a = base + AW'(4 * i);
      push_cmd(0, a, min4(b - 4 * i), '0, '0);
    end
    afu_bus.read = 1'b1; afu_bus.address = base; afu_bus.burstcount = 7'(b);
    while (!done && n < 64) begin
      stall = (stalls && n < 40) ? 1'($urandom_range(0, 1)) : 1'b0;
      fiu_bus.waitrequest = stall;
      @(negedge clk);
      chk("rd_waitrequest", afu_bus.waitrequest, (k == nch - 1) ? stall : 1'b1);
      if (!stall) begin
        if (k == nch - 1) done = 1;
        k++;
      end
      n++;
      @(posedge clk); #1;
    end
    if (!done) chk("rd_timeout", 0, 1);
    afu_bus.read = 1'b0; fiu_bus.waitrequest = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] base, input int unsigned b, input bit stalls);
    logic [DW-1:0] d;
    logic [7:0] be;
    logic [AW-1:0] a;
    bit acc, stall;
    int unsigned n, ch;
    for (int unsigned i = 0; i < b; i++) begin
      if (stalls && $urandom_range(0, 2) == 0) begin
        afu_bus.write = 1'b0;
        fiu_bus.waitrequest = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("wr_gap_no_fiu_write", fiu_bus.write, 0);
        @(posedge clk); #1;
      end
      d  = {$urandom, $urandom};
      be = 8'($urandom);
      ch = i / 4;
      a  = base + AW'(4 * ch);
      push_cmd(1, a, min4(b - 4 * ch), d, be);
      afu_bus.write = 1'b1; afu_bus.address = base; afu_bus.burstcount = 7'(b);
      afu_bus.writedata = d; afu_bus.byteenable = be;
      acc = 0; n = 0;
      while (!acc && n < 16) begin
        stall = (stalls && n < 8) ? 1'($urandom_range(0, 1)) : 1'b0;
        fiu_bus.waitrequest = stall;
        @(negedge clk);
        chk("wr_waitrequest", afu_bus.waitrequest, stall);
        acc = !stall; n++;
        @(posedge clk); #1;
      end
      if (!acc) chk("wr_timeout", 0, 1);
    end
    afu_bus.write = 1'b0; fiu_bus.waitrequest = 1'b0;
  endtask

  initial begin
    int unsigned n;
    reset = 1'b1;
    afu_bus.read = 1'b1; afu_bus.write = 1'b0; afu_bus.burstcount = 7'd1;
    afu_bus.address = '0; afu_bus.writedata = '0; afu_bus.byteenable = '0;
    fiu_bus.waitrequest = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_fiu_read", fiu_bus.read, 0);
    chk("reset_fiu_write", fiu_bus.write, 0);
    chk("reset_afu_waitrequest", afu_bus.waitrequest, 1);
    @(posedge clk); #1;
    reset = 1'b0; afu_bus.read = 1'b0;
    @(posedge clk); #1;

    do_read(27'h100, 4, 0);            // exactly FIU_MAX: single chunk
    do_read(27'h100, 10, 0);           // three chunks on consecutive cycles
    do_write(27'h200, 6, 0);           // chunk boundary at beat 5
    do_write(27'h200, 6, 1);           // same, with stalls and idle gaps
    do_write(27'h050, 1, 0);           // single-beat write
    do_read(27'h7FFFFFE, 8, 0);        // wraps past top of address space
    do_read(27'h180, 7, 1);            // split read under stalls
    do_write(27'h3F0, 9, 1);           // three write chunks under stalls

    // Reset after the first chunk of a 10-line read.
    push_cmd(0, 27'h300, 3'd4, '0, '0);
    afu_bus.read = 1'b1; afu_bus.address = 27'h300; afu_bus.burstcount = 7'd10;
    @(negedge clk);
    chk("rst_mid_first_wait", afu_bus.waitrequest, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("rst_mid_fiu_read", fiu_bus.read, 0);
    afu_bus.read = 1'b0;
    @(negedge clk);
    chk("rst_mid_afu_wait", afu_bus.waitrequest, 1);
    @(posedge clk); #1;
    reset = 1'b0;
    do_read(27'h040, 1, 0);

    n = 0;
    while ((exp_rd_q.size() != 0 || exp_cmd.size() != 0) && n < 300) begin
      @(posedge clk); n++;
    end
    @(negedge clk);
    chk("rd_beats_left", exp_rd_q.size(), 0);
    chk("cmds_left", exp_cmd.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
